// File: rtl/digit_serial_multiplier_pkg.sv
// Shared types and constants for the digit-serial multiplier: FSM encoding,
// digit width and the digits-per-operand helper.
package digit_serial_multiplier_pkg;

  localparam int DIGIT_W = 2;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int digit_count(input int width);
    return width / DIGIT_W;
  endfunction

endpackage

// File: rtl/digit_serial_multiplier_bit2.sv
// Gate-level 2-bit x 2-bit unsigned multiplier cell, purely combinational.
// Used as the partial-product generator of the digit-serial multiplier.
module Bit2_Multiplier (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);

  logic t1, t2, t3, c1;

  assign p[0] = a[0] & b[0];
  assign t1   = a[1] & b[0];
  assign t2   = a[0] & b[1];
  assign p[1] = t1 ^ t2;
  assign c1   = t1 & t2;
  assign t3   = a[1] & b[1];
  assign p[2] = t3 ^ c1;
  assign p[3] = t3 & c1;

endmodule

// File: rtl/digit_serial_multiplier.sv
// Unsigned WIDTH x WIDTH multiplier, one 2x2 digit product per cycle (D*D cycles
// after accept); result held in DONE until out_ready, no new accept until then.
module digit_serial_multiplier
  import digit_serial_multiplier_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int D     = digit_count(WIDTH);
  localparam int PW    = 2 * WIDTH;
  localparam int IDX_W = (D > 1) ? $clog2(D) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(D - 1);

  if (((WIDTH % 2) != 0) || (WIDTH < 2)) begin : g_width_check
    $error("digit_serial_multiplier: WIDTH must be even and >= 2");
  end

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [PW-1:0]      acc;
  logic [IDX_W-1:0]   i_q, j_q;
  logic [DIGIT_W-1:0] a_dig, b_dig;
  logic [3:0]         pp;
  logic [PW-1:0]      pp_ext, shamt, pp_shift;
  logic               last_step;

  assign a_dig     = a_q[DIGIT_W*i_q +: DIGIT_W];
  assign b_dig     = b_q[DIGIT_W*j_q +: DIGIT_W];
  assign last_step = (i_q == LAST) && (j_q == LAST);

  Bit2_Multiplier u_cell (
    .a (a_dig),
    .b (b_dig),
    .p (pp)
  );

  // Weight of digit pair (i,j) is 4^(i+j); kept at full product width.
  assign pp_ext   = PW'(pp);
  assign shamt    = PW'(DIGIT_W) * (PW'(i_q) + PW'(j_q));
  assign pp_shift = pp_ext << shamt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      i_q <= '0;
      j_q <= '0;
    end else if (state == IDLE && in_valid) begin
      a_q <= a;
      b_q <= b;
      acc <= '0;
      i_q <= '0;
      j_q <= '0;
    end else if (state == BUSY) begin
      acc <= acc + pp_shift;
      // Indices park at zero after the final digit pair.
      if (j_q == LAST) begin
        j_q <= '0;
        i_q <= (i_q == LAST) ? '0 : i_q + 1'b1;
      end else begin
        j_q <= j_q + 1'b1;
      end
    end
  end

  assign p = acc;

endmodule

// File: tb/tb_digit_serial_multiplier.sv
// Bench for digit_serial_multiplier: WIDTH=8 and WIDTH=2 instances, scoreboard queues.
module tb_digit_serial_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic        in_ready, out_valid, busy;
  logic [15:0] p;

  logic        in_valid2 = 1'b0, out_ready2 = 1'b1;
  logic [1:0]  a2 = '0, b2 = '0;
  logic        in_ready2, out_valid2, busy2;
  logic [3:0]  p2;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [3:0]  exp2_q[$];

  always #5 clk = ~clk;

  digit_serial_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .busy(busy)
  );

  digit_serial_multiplier #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(out_ready2),
    .p(p2), .busy(busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one operand pair into the WIDTH=8 instance and record the expected product.
  task automatic start8(input logic [7:0] av, input logic [7:0] bv);
    int n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL start_wait: in_ready=%0b required 1 within 50 cycles", in_ready);
    end
    a = av; b = bv; in_valid = 1'b1;
    exp_q.push_back(16'(av) * 16'(bv));
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [15:0] pop8();
    if (exp_q.size() == 0) return 16'hxxxx;
    return exp_q.pop_front();
  endfunction

  task automatic run_one(input logic [7:0] av, input logic [7:0] bv, input int hold, input string nm);
    int n = 0;
    logic [15:0] snap;
    out_ready = (hold == 0);
    start8(av, bv);
    while (!out_valid && n < 100) begin tick(); n++; end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL %s_timeout: out_valid=%0b required 1", nm, out_valid);
    end
    snap = p;
    for (int k = 0; k < hold; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || p !== snap) begin
        errors++;
        $display("FAIL %s_hold: out_valid=%0b p=%h required 1 p=%h", nm, out_valid, p, snap);
      end
    end
    checks++;
    begin
      logic [15:0] e = pop8();
      if (p !== e) begin errors++; $display("FAIL %s_product: p=%h required %h", nm, p, e); end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_handshake: out_valid=%0b in_ready=%0b required 0 1", nm, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || p !== 16'h0) begin
      errors++;
      $display("FAIL reset8: in_ready=%0b out_valid=%0b busy=%0b p=%h required 1 0 0 0000",
               in_ready, out_valid, busy, p);
    end
    checks++;
    if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0 || busy2 !== 1'b0 || p2 !== 4'h0) begin
      errors++;
      $display("FAIL reset2: in_ready=%0b out_valid=%0b busy=%0b p=%h required 1 0 0 0",
               in_ready2, out_valid2, busy2, p2);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    int n = 0;
    out_ready = 1'b1;
    start8(8'd3, 8'd5);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL basic_busy: busy=%0b in_ready=%0b required 1 0", busy, in_ready);
    end
    while (!out_valid && n < 100) begin tick(); n++; end
    checks++;
    if (n != 16) begin errors++; $display("FAIL basic_latency: cycles=%0d required 16", n); end
    checks++;
    begin
      logic [15:0] e = pop8();
      if (p !== e || p !== 16'h000F) begin errors++; $display("FAIL basic_product: p=%h required 000f", p); end
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_ready_after: in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_corners();
    run_one(8'd255, 8'd255, 0, "max");
    run_one(8'd0, 8'd200, 0, "zero");
  endtask

  task automatic test_backpressure();
    int extra = 0;
    run_one(8'd12, 8'd34, 5, "bp");
    for (int k = 0; k < 20; k++) begin
      tick();
      if (out_valid) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL bp_single: extra out_valid cycles=%0d required 0", extra); end
  endtask

  task automatic test_ignored_input();
    int n = 0;
    int extra = 0;
    out_ready = 1'b1;
    start8(8'd10, 8'd20);
    tick(); tick(); tick();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL ign_ready: in_ready=%0b required 0", in_ready); end
    a = 8'd7; b = 8'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    while (!out_valid && n < 100) begin tick(); n++; end
    checks++;
    begin
      logic [15:0] e = pop8();
      if (out_valid !== 1'b1 || p !== e) begin
        errors++; $display("FAIL ign_product: out_valid=%0b p=%h required 1 %h", out_valid, p, e);
      end
    end
    for (int k = 0; k < 25; k++) begin
      tick();
      if (out_valid || !in_ready) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL ign_not_accepted: stray cycles=%0d required 0", extra); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    start8(8'd100, 8'd100);
    repeat (6) tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy: busy=%0b required 1", busy); end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || p !== 16'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rmid_abort: out_valid=%0b p=%h in_ready=%0b busy=%0b required 0 0000 1 0",
               out_valid, p, in_ready, busy);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    tick();
    run_one(8'd9, 8'd9, 0, "rmid_after");
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 200; t++) begin
      int n = 0;
      bit done = 0;
      start8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      while (!done && n < 200) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          logic [15:0] e = pop8();
          checks++;
          if (p !== e) begin errors++; $display("FAIL b2b_product[%0d]: p=%h required %h", t, p, e); end
          done = 1;
        end
        tick(); n++;
      end
      if (!done) begin
        checks++; errors++; $display("FAIL b2b_timeout[%0d]: no output handshake", t);
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_width2();
    out_ready2 = 1'b1;
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        a2 = 2'(x); b2 = 2'(y); in_valid2 = 1'b1;
        exp2_q.push_back(4'(x * y));
        checks++;
        if (in_ready2 !== 1'b1) begin errors++; $display("FAIL w2_ready[%0d,%0d]: in_ready=%0b required 1", x, y, in_ready2); end
        tick();
        in_valid2 = 1'b0;
        checks++;
        if (busy2 !== 1'b1 || out_valid2 !== 1'b0) begin
          errors++; $display("FAIL w2_busy[%0d,%0d]: busy=%0b out_valid=%0b required 1 0", x, y, busy2, out_valid2);
        end
        tick();
        checks++;
        begin
          logic [3:0] e = exp2_q.pop_front();
          if (out_valid2 !== 1'b1 || p2 !== e) begin
            errors++; $display("FAIL w2_product[%0d,%0d]: out_valid=%0b p=%h required 1 %h", x, y, out_valid2, p2, e);
          end
        end
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_ignored_input();
    test_reset_mid();
    test_back_to_back();
    test_width2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
